grpci2_cmd_splitter: RTL and testbench

Sequencer placed in front of one command channel (write or read) of the PCI-side AHB master controller. It accepts one AXI-style burst command and splits it into sub-commands. No sub-command crosses a cache-line boundary (from the PCI config-space cacheline_size), a 4 KB boundary, or MAX_BEATS. Sub-commands are issued one at a time. The block waits for each sub-response, merges the error codes, and returns one response for the whole burst. Two instances are used: one on wcmd/wresp, one on rcmd/rresp.

---
 rtl/grpci2_cmd_splitter_if.sv | 36 +++
 rtl/grpci2_cmd_splitter.sv | 144 ++++++++++++++
 tb/tb_grpci2_cmd_splitter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/grpci2_cmd_splitter_if.sv
// Command/response bundle around the burst splitter: upstream burst channel (s_*)
// and downstream sub-command channel (m_*). The splitter uses the slave modport.
interface grpci2_cmd_splitter_if;
  logic [3:0]  s_cmd_id;
  logic [7:0]  s_cmd_len;
  logic [63:0] s_cmd_addr;
  logic        s_cmd_valid;
  logic        s_cmd_ready;
  logic [3:0]  s_resp_id;
  logic [7:0]  s_resp_len;
  logic [1:0]  s_resp_err;
  logic        s_resp_valid;
  logic        s_resp_ready;
  logic [3:0]  m_cmd_id;
  logic [7:0]  m_cmd_len;
  logic [63:0] m_cmd_addr;
  logic        m_cmd_valid;
  logic        m_cmd_ready;
  logic [1:0]  m_resp_err;
  logic        m_resp_valid;
  logic        m_resp_ready;

  modport master (
    output s_cmd_id, s_cmd_len, s_cmd_addr, s_cmd_valid, s_resp_ready,
           m_cmd_ready, m_resp_err, m_resp_valid,
    input  s_cmd_ready, s_resp_id, s_resp_len, s_resp_err, s_resp_valid,
           m_cmd_id, m_cmd_len, m_cmd_addr, m_cmd_valid, m_resp_ready
  );

  modport slave (
    input  s_cmd_id, s_cmd_len, s_cmd_addr, s_cmd_valid, s_resp_ready,
           m_cmd_ready, m_resp_err, m_resp_valid,
    output s_cmd_ready, s_resp_id, s_resp_len, s_resp_err, s_resp_valid,
           m_cmd_id, m_cmd_len, m_cmd_addr, m_cmd_valid, m_resp_ready
  );
endinterface

// File: rtl/grpci2_cmd_splitter.sv
// Splits one burst command into cache-line / 4 KB / MAX_BEATS bounded sub-commands.
// Define GRPCI2_SPLIT_ABORT_EN to stop issuing sub-commands after the first error response.
module grpci2_cmd_splitter #(
  parameter int MAX_BEATS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cacheline_size,
  grpci2_cmd_splitter_if.slave bus
);

  localparam logic [10:0] MAX_W = 11'(MAX_BEATS);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  id;
  logic [7:0]  len;
  logic [63:0] addr;
  logic [10:0] rem;
  logic [10:0] chunk;
  logic [1:0]  err_acc;
  logic [63:0] m_cmd_addr_q;

  logic [7:0]  cl_mask;
  logic        cl_en;
  logic [10:0] to_4k;
  logic [10:0] to_cl;
  logic [10:0] chunk_calc;
  logic [10:0] rem_next;
  logic [1:0]  err_next;
  logic        cmd_acc;
  logic        sub_acc;
  logic        last;

  function automatic logic [10:0] min11(input logic [10:0] a, input logic [10:0] b);
    return (a < b) ? a : b;
  endfunction

  // Error codes are ordered by severity, so merging is a plain maximum.
  function automatic logic [1:0] worst_err(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    cl_mask    = cacheline_size - 8'd1;
    cl_en      = (cacheline_size != 8'd0) && ((cacheline_size & cl_mask) == 8'd0);
    to_4k      = 11'd1024 - {1'b0, addr[11:2]};
    to_cl      = {3'b000, cacheline_size} - {3'b000, addr[9:2] & cl_mask};
    chunk_calc = min11(min11(rem, MAX_W), to_4k);
    if (cl_en) chunk_calc = min11(chunk_calc, to_cl);
    rem_next   = rem - chunk;
    err_next   = worst_err(err_acc, bus.m_resp_err);
    cmd_acc    = (state == IDLE) && bus.s_cmd_ready && bus.s_cmd_valid;
    sub_acc    = (state == WAIT) && bus.m_resp_ready && bus.m_resp_valid;
`ifdef GRPCI2_SPLIT_ABORT_EN
    last       = (rem_next == 11'd0) || (bus.m_resp_err != 2'd0);
`else
    last       = (rem_next == 11'd0);
`endif
  end

  assign bus.m_cmd_id   = id;
  assign bus.m_cmd_addr = m_cmd_addr_q;
  assign bus.s_resp_id  = id;
  assign bus.s_resp_len = len;

  // Control: state and every handshake output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      bus.s_cmd_ready  <= 1'b0;
      bus.s_resp_valid <= 1'b0;
      bus.s_resp_err   <= 2'd0;
      bus.m_cmd_valid  <= 1'b0;
      bus.m_cmd_len    <= 8'd0;
      bus.m_resp_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_acc) begin
            bus.s_cmd_ready <= 1'b0;
            state           <= CALC;
          end else begin
            bus.s_cmd_ready <= 1'b1;
          end
        end
        CALC: begin
          bus.m_cmd_len   <= 8'(chunk_calc - 11'd1);
          bus.m_cmd_valid <= 1'b1;
          state           <= ISSUE;
        end
        ISSUE: begin
          if (bus.m_cmd_ready) begin
            bus.m_cmd_valid  <= 1'b0;
            bus.m_resp_ready <= 1'b1;
            state            <= WAIT;
          end
        end
        WAIT: begin
          if (sub_acc) begin
            bus.m_resp_ready <= 1'b0;
            if (last) begin
              bus.s_resp_valid <= 1'b1;
              bus.s_resp_err   <= err_next;
              state            <= RESP;
            end else begin
              state <= CALC;
            end
          end
        end
        RESP: begin
          if (bus.s_resp_ready) begin
            bus.s_resp_valid <= 1'b0;
            bus.s_cmd_ready  <= 1'b1;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: burst context, walked forward one sub-command at a time.
  always_ff @(posedge clk) begin
    if (cmd_acc) begin
      id      <= bus.s_cmd_id;
      len     <= bus.s_cmd_len;
      addr    <= bus.s_cmd_addr;
      rem     <= {3'b000, bus.s_cmd_len} + 11'd1;
      err_acc <= 2'd0;
    end
    if (state == CALC) begin
      chunk        <= chunk_calc;
      m_cmd_addr_q <= addr;
    end
    if (sub_acc) begin
      err_acc <= err_next;
      rem     <= rem_next;
      addr    <= {addr[63:2], 2'b00} + {51'd0, chunk, 2'b00};
    end
  end

endmodule

// File: tb/tb_grpci2_cmd_splitter.sv
// Directed bench for grpci2_cmd_splitter: burst splitting, error merge, stalls and reset.
module tb_grpci2_cmd_splitter;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cls = 8'd0;
  int errors = 0;
  int checks = 0;

  grpci2_cmd_splitter_if bus();

  grpci2_cmd_splitter #(.MAX_BEATS(16)) dut (
    .clk(clk),
    .rst(rst),
    .cacheline_size(cls),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [3:0] id, input logic [7:0] len, input logic [63:0] addr);
    int n = 0;
    while (bus.s_cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("s_cmd_ready_wait", bus.s_cmd_ready, 1);
    bus.s_cmd_id    = id;
    bus.s_cmd_len   = len;
    bus.s_cmd_addr  = addr;
    bus.s_cmd_valid = 1'b1;
    @(negedge clk);
    bus.s_cmd_valid = 1'b0;
    chk("s_cmd_ready_drop", bus.s_cmd_ready, 0);
  endtask

  task automatic expect_sub(input string tag, input logic [3:0] id, input logic [63:0] addr,
                            input logic [7:0] len, input logic [1:0] err, input int hold);
    int n = 0;
    while (bus.m_cmd_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, bus.m_cmd_valid, 1);
    chk({tag, "_addr"}, bus.m_cmd_addr, addr);
    chk({tag, "_len"}, bus.m_cmd_len, len);
    chk({tag, "_id"}, bus.m_cmd_id, id);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, bus.m_cmd_valid, 1);
      chk({tag, "_hold_addr"}, bus.m_cmd_addr, addr);
      chk({tag, "_hold_len"}, bus.m_cmd_len, len);
    end
    bus.m_cmd_ready = 1'b1;
    @(negedge clk);
    bus.m_cmd_ready = 1'b0;
    chk({tag, "_valid_drop"}, bus.m_cmd_valid, 0);
    chk({tag, "_resp_ready"}, bus.m_resp_ready, 1);
    bus.m_resp_err   = err;
    bus.m_resp_valid = 1'b1;
    @(negedge clk);
    bus.m_resp_valid = 1'b0;
    bus.m_resp_err   = 2'd0;
    chk({tag, "_resp_ready_drop"}, bus.m_resp_ready, 0);
  endtask

  task automatic expect_resp(input string tag, input logic [3:0] id, input logic [7:0] len,
                             input logic [1:0] err, input int hold);
    int n = 0;
    while (bus.s_resp_valid !== 1'b1 && bus.m_cmd_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, bus.s_resp_valid, 1);
    chk({tag, "_no_extra_sub"}, bus.m_cmd_valid, 0);
    chk({tag, "_id"}, bus.s_resp_id, id);
    chk({tag, "_len"}, bus.s_resp_len, len);
    chk({tag, "_err"}, bus.s_resp_err, err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_valid"}, bus.s_resp_valid, 1);
      chk({tag, "_hold_id"}, bus.s_resp_id, id);
      chk({tag, "_hold_len"}, bus.s_resp_len, len);
      chk({tag, "_hold_err"}, bus.s_resp_err, err);
    end
    bus.s_resp_ready = 1'b1;
    @(negedge clk);
    bus.s_resp_ready = 1'b0;
    chk({tag, "_valid_drop"}, bus.s_resp_valid, 0);
    chk({tag, "_cmd_ready_back"}, bus.s_cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_cmd_id     = 4'd0;
    bus.s_cmd_len    = 8'd0;
    bus.s_cmd_addr   = 64'd0;
    bus.s_cmd_valid  = 1'b0;
    bus.s_resp_ready = 1'b0;
    bus.m_cmd_ready  = 1'b0;
    bus.m_resp_err   = 2'd0;
    bus.m_resp_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_s_cmd_ready", bus.s_cmd_ready, 0);
    chk("rst_s_resp_valid", bus.s_resp_valid, 0);
    chk("rst_s_resp_err", bus.s_resp_err, 0);
    chk("rst_m_cmd_valid", bus.m_cmd_valid, 0);
    chk("rst_m_cmd_len", bus.m_cmd_len, 0);
    chk("rst_m_resp_ready", bus.m_resp_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_s_cmd_ready", bus.s_cmd_ready, 1);

    // 1: cache-line split, with two-cycle command latency
    cls = 8'd8;
    send_cmd(4'd1, 8'd15, 64'h1000_0038);
    chk("t1_lat_cycle1", bus.m_cmd_valid, 0);
    @(negedge clk);
    chk("t1_lat_cycle2", bus.m_cmd_valid, 1);
    expect_sub("t1_s0", 4'd1, 64'h1000_0038, 8'd1, 2'd0, 0);
    expect_sub("t1_s1", 4'd1, 64'h1000_0040, 8'd7, 2'd0, 0);
    expect_sub("t1_s2", 4'd1, 64'h1000_0060, 8'd5, 2'd0, 0);
    expect_resp("t1_resp", 4'd1, 8'd15, 2'd0, 0);

    // 2: 4 KB crossing
    cls = 8'd0;
    send_cmd(4'd2, 8'd3, 64'h0000_0FF8);
    expect_sub("t2_s0", 4'd2, 64'h0000_0FF8, 8'd1, 2'd0, 0);
    expect_sub("t2_s1", 4'd2, 64'h0000_1000, 8'd1, 2'd0, 0);
    expect_resp("t2_resp", 4'd2, 8'd3, 2'd0, 0);

    // 3: MAX_BEATS split
    send_cmd(4'd3, 8'd39, 64'h0);
    expect_sub("t3_s0", 4'd3, 64'h00, 8'd15, 2'd0, 0);
    expect_sub("t3_s1", 4'd3, 64'h40, 8'd15, 2'd0, 0);
    expect_sub("t3_s2", 4'd3, 64'h80, 8'd7, 2'd0, 0);
    expect_resp("t3_resp", 4'd3, 8'd39, 2'd0, 0);

    // 4: error merge (middle sub-command answers SLVERR)
    send_cmd(4'd4, 8'd39, 64'h0);
    expect_sub("t4_s0", 4'd4, 64'h00, 8'd15, 2'd0, 0);
    expect_sub("t4_s1", 4'd4, 64'h40, 8'd15, 2'd2, 0);
`ifndef GRPCI2_SPLIT_ABORT_EN
    expect_sub("t4_s2", 4'd4, 64'h80, 8'd7, 2'd0, 0);
`endif
    expect_resp("t4_resp", 4'd4, 8'd39, 2'd2, 0);

    // 5: unaligned single beat, stalls on both sides, stray sub-response ignored
    cls = 8'd16;
    send_cmd(4'd5, 8'd0, 64'h102);
    bus.m_resp_err   = 2'd3;
    bus.m_resp_valid = 1'b1;
    expect_sub("t5_s0", 4'd5, 64'h102, 8'd0, 2'd0, 5);
    expect_resp("t5_resp", 4'd5, 8'd0, 2'd0, 3);

    // Non-power-of-two cache line disables that rule; DECERR propagates
    cls = 8'd6;
    send_cmd(4'd9, 8'd3, 64'h10);
    expect_sub("np2_s0", 4'd9, 64'h10, 8'd3, 2'd3, 0);
    expect_resp("np2_resp", 4'd9, 8'd3, 2'd3, 0);

    // 6: reset while waiting for a sub-response
    cls = 8'd0;
    send_cmd(4'd6, 8'd39, 64'h0);
    @(negedge clk);
    chk("t6_issue_valid", bus.m_cmd_valid, 1);
    bus.m_cmd_ready = 1'b1;
    @(negedge clk);
    bus.m_cmd_ready = 1'b0;
    chk("t6_in_wait", bus.m_resp_ready, 1);
    rst = 1'b1;
    #1;
    chk("t6_async_m_resp_ready", bus.m_resp_ready, 0);
    @(negedge clk);
    chk("t6_rst_m_cmd_valid", bus.m_cmd_valid, 0);
    chk("t6_rst_s_resp_valid", bus.s_resp_valid, 0);
    chk("t6_rst_m_resp_ready", bus.m_resp_ready, 0);
    chk("t6_rst_s_cmd_ready", bus.s_cmd_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_release_s_cmd_ready", bus.s_cmd_ready, 1);
    chk("t6_release_m_cmd_valid", bus.m_cmd_valid, 0);
    send_cmd(4'd7, 8'd0, 64'h2000);
    expect_sub("t6_s0", 4'd7, 64'h2000, 8'd0, 2'd0, 0);
    expect_resp("t6_resp", 4'd7, 8'd0, 2'd0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
